// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the EX/MEM/WB hazard scoreboard.
// Entry widths are fixed here; the top-level AW/TW defaults track them.
package hazard_pkg;
   localparam int SB_AW = 5;
   localparam int SB_TW = 2;

   localparam logic [1:0]       SEL_RF    = 2'd0;
   localparam logic [1:0]       SEL_EXMEM = 2'd1;
   localparam logic [1:0]       SEL_MEMWB = 2'd2;
   localparam logic [SB_TW-1:0] TUSE_NONE = 2'd3;
   localparam logic [SB_TW-1:0] TNEW_ALU  = 2'd1;
   localparam logic [SB_TW-1:0] TNEW_LOAD = 2'd2;

   typedef enum logic [1:0] {STG_EX, STG_MEM, STG_WB} stage_e;

   typedef struct packed {
      logic             v;
      logic [SB_AW-1:0] wa;
      logic [SB_TW-1:0] tnew;
   } sb_entry_t;

   typedef struct packed {
      logic             hit;
      stage_e           stage;
      logic [SB_TW-1:0] tnew;
   } match_t;

   function automatic logic [SB_TW-1:0] tnew_dec(input logic [SB_TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard response bundle between decode and the scoreboard.
interface hazard_scoreboard_if #(parameter int AW = 5, parameter int TW = 2);
   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic [TW-1:0] id_tuse_rs;
   logic [TW-1:0] id_tuse_rt;
   logic [AW-1:0] id_wa;
   logic [TW-1:0] id_tnew;
   logic          flush;
   logic          stall;
   logic [1:0]    fwd_sel_rs;
   logic [1:0]    fwd_sel_rt;

   modport master (output id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_wa, id_tnew, flush,
                   input  stall, fwd_sel_rs, fwd_sel_rt);
   modport slave  (input  id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_wa, id_tnew, flush,
                   output stall, fwd_sel_rs, fwd_sel_rt);
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Youngest-producer priority encoder for one source register (EX > MEM > WB).
module sb_match
   import hazard_pkg::*;
(
   input  logic [SB_AW-1:0] src,
   input  sb_entry_t        ex,
   input  sb_entry_t        mem,
   input  sb_entry_t        wb,
   output match_t           m
);
   always_comb begin
      m = '0;
      if (src != '0) begin
         if (ex.v && ex.wa == src)        m = '{hit: 1'b1, stage: STG_EX,  tnew: ex.tnew};
         else if (mem.v && mem.wa == src) m = '{hit: 1'b1, stage: STG_MEM, tnew: mem.tnew};
         else if (wb.v && wb.wa == src)   m = '{hit: 1'b1, stage: STG_WB,  tnew: wb.tnew};
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks EX/MEM/WB producers, raises the ID stall and registers the EX operand
// forwarding selects. Index 0 is rs, index 1 is rt throughout.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int AW     = SB_AW,
   parameter int TW     = SB_TW,
   parameter bit FWD_EN = 1'b1
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave hif
);
   sb_entry_t               ex_q, mem_q, wb_q;
   logic [1:0][SB_AW-1:0]   src;
   logic [1:0][SB_TW-1:0]   tuse;
   match_t                  m [2];
   logic [1:0]              hz;
   logic [1:0][1:0]         sel_d, sel_q;
   logic                    stall, load;

   assign src  = {hif.id_rt, hif.id_rs};
   assign tuse = {hif.id_tuse_rt, hif.id_tuse_rs};

   for (genvar i = 0; i < 2; i++) begin : g_src
      sb_match u_match (.src(src[i]), .ex(ex_q), .mem(mem_q), .wb(wb_q), .m(m[i]));
   end

   // Without forwarding any in-flight producer blocks until it has left WB.
   always_comb begin
      hz = '0;
      for (int i = 0; i < 2; i++)
         if (tuse[i] != TUSE_NONE && m[i].hit)
            hz[i] = FWD_EN ? (m[i].tnew > tuse[i]) : 1'b1;
   end

   assign stall = hif.id_valid & (|hz);
   assign load  = hif.id_valid & ~stall & ~hif.flush;

   always_comb begin
      sel_d = '0;
      for (int i = 0; i < 2; i++)
         if (FWD_EN && load && tuse[i] != TUSE_NONE && m[i].hit)
            case (m[i].stage)
               STG_EX:  sel_d[i] = SEL_EXMEM;
               STG_MEM: sel_d[i] = SEL_MEMWB;
               default: sel_d[i] = SEL_RF;
            endcase
   end

   // WB hits fall back to the register file, which writes through to ID.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         sel_q <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= '{v: ex_q.v, wa: ex_q.wa, tnew: tnew_dec(ex_q.tnew)};
         ex_q  <= '{v: load && hif.id_wa != '0, wa: hif.id_wa, tnew: hif.id_tnew};
         sel_q <= sel_d;
      end
   end

   assign hif.stall      = stall;
   assign hif.fwd_sel_rs = sel_q[0];
   assign hif.fwd_sel_rt = sel_q[1];
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: forwarding and non-forwarding instances share stimulus and
// are checked against an in-flight-instruction model (age 0=EX, 1=MEM, 2=WB).
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   typedef struct {int wa; int tnew; int age;} inflt_t;
   typedef inflt_t iq_t[$];
   typedef struct packed {
      logic [1:0]      stall;
      logic [1:0][1:0] srs;
      logic [1:0][1:0] srt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_scoreboard_if hif_f ();
   hazard_scoreboard_if hif_n ();

   hazard_scoreboard #(.FWD_EN(1'b1)) u_fwd   (.clk(clk), .reset(reset), .hif(hif_f));
   hazard_scoreboard #(.FWD_EN(1'b0)) u_nofwd (.clk(clk), .reset(reset), .hif(hif_n));

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t expq[$];
   iq_t  fl[2];
   int   cur_rs[2];
   int   cur_rt[2];
   bit   done = 0;

   function automatic void chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endfunction

   // Youngest in-flight producer of s; its current tnew counts down once it leaves EX.
   function automatic void lookup(input iq_t q, input int s, output bit hit, output int age,
                                  output int ct);
      hit = 0; age = 0; ct = 0;
      if (s == 0) return;
      foreach (q[k])
         if (q[k].wa == s && (!hit || q[k].age < age)) begin
            hit = 1;
            age = q[k].age;
            ct  = (q[k].age == 0) ? q[k].tnew : ((q[k].tnew > 0) ? q[k].tnew - 1 : 0);
         end
   endfunction

   function automatic int sel_of(input bit use_it, input int age);
      if (!use_it) return 0;
      return (age == 0) ? 1 : (age == 1) ? 2 : 0;
   endfunction

   task automatic cycle(input bit v, input int rs, input int rt, input int tus, input int tut,
                        input int wa, input int tn, input bit flsh, input bit rst_low = 0);
      exp_t e;
      bit   h0, h1, hz0, hz1, st, fwd;
      int   a0, a1, c0, c1;
      bit   ld[2];
      int   nrs[2], nrt[2];
      iq_t  nq;
      inflt_t x;
      hif_f.id_valid = v;        hif_n.id_valid = v;
      hif_f.id_rs = 5'(rs);      hif_n.id_rs = 5'(rs);
      hif_f.id_rt = 5'(rt);      hif_n.id_rt = 5'(rt);
      hif_f.id_tuse_rs = 2'(tus); hif_n.id_tuse_rs = 2'(tus);
      hif_f.id_tuse_rt = 2'(tut); hif_n.id_tuse_rt = 2'(tut);
      hif_f.id_wa = 5'(wa);      hif_n.id_wa = 5'(wa);
      hif_f.id_tnew = 2'(tn);    hif_n.id_tnew = 2'(tn);
      hif_f.flush = flsh;        hif_n.flush = flsh;
      if (rst_low) begin
         #1 reset = 1'b0;
         for (int d = 0; d < 2; d++) begin
            fl[d].delete();
            cur_rs[d] = 0;
            cur_rt[d] = 0;
         end
      end else reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         fwd = (d == 0);
         lookup(fl[d], rs, h0, a0, c0);
         lookup(fl[d], rt, h1, a1, c1);
         hz0 = tus != 3 && h0 && (!fwd || c0 > tus);
         hz1 = tut != 3 && h1 && (!fwd || c1 > tut);
         st  = v && (hz0 || hz1);
         ld[d]  = v && !st && !flsh;
         nrs[d] = sel_of(fwd && ld[d] && tus != 3 && h0, a0);
         nrt[d] = sel_of(fwd && ld[d] && tut != 3 && h1, a1);
         e.stall[d] = st;
         e.srs[d]   = 2'(cur_rs[d]);
         e.srt[d]   = 2'(cur_rt[d]);
      end
      expq.push_back(e);
      @(posedge clk);
      if (!rst_low)
         for (int d = 0; d < 2; d++) begin
            nq = {};
            foreach (fl[d][k])
               if (fl[d][k].age < 2) begin
                  x = fl[d][k];
                  x.age++;
                  nq.push_back(x);
               end
            if (ld[d] && wa != 0) nq.push_back('{wa: wa, tnew: tn, age: 0});
            fl[d] = nq;
            cur_rs[d] = nrs[d];
            cur_rt[d] = nrt[d];
         end
      #2;
   endtask

   task automatic nop(input int n = 1);
      repeat (n) cycle(0, 0, 0, 3, 3, 0, 0, 0);
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stall_fwd",    int'(hif_f.stall),      int'(e.stall[0]));
            chk("stall_nofwd",  int'(hif_n.stall),      int'(e.stall[1]));
            chk("sel_rs_fwd",   int'(hif_f.fwd_sel_rs), int'(e.srs[0]));
            chk("sel_rt_fwd",   int'(hif_f.fwd_sel_rt), int'(e.srt[0]));
            chk("sel_rs_nofwd", int'(hif_n.fwd_sel_rs), int'(e.srs[1]));
            chk("sel_rt_nofwd", int'(hif_n.fwd_sel_rt), int'(e.srt[1]));
         end
      end
   end

   initial begin
      int t0, t1;
      reset = 1'b0;
      @(posedge clk);
      #2;
      cycle(0, 0, 0, 3, 3, 0, 0, 0, 1);
      nop(2);
      // back-to-back ALU
      cycle(1, 0, 0, 3, 3, 3, TNEW_ALU, 0);
      cycle(1, 3, 0, 1, 3, 0, 1, 0);
      nop(3);
      // load-use, consumer held while stalled
      cycle(1, 0, 0, 3, 3, 5, TNEW_LOAD, 0);
      repeat (2) cycle(1, 5, 0, 1, 3, 6, 1, 0);
      nop(3);
      // branch after ALU
      cycle(1, 0, 0, 3, 3, 4, TNEW_ALU, 0);
      repeat (2) cycle(1, 4, 0, 0, 3, 0, 1, 0);
      nop(3);
      // $0 never matches; youngest of two $7 producers wins
      cycle(1, 0, 0, 3, 3, 0, 1, 0);
      cycle(1, 0, 0, 1, 0, 0, 1, 0);
      nop(1);
      cycle(1, 0, 0, 3, 3, 7, 1, 0);
      cycle(1, 0, 0, 3, 3, 7, 1, 0);
      cycle(1, 7, 7, 1, 1, 8, 1, 0);
      nop(3);
      // flushed producer never enters; stall plus flush still bubbles
      cycle(1, 0, 0, 3, 3, 9, 1, 1);
      cycle(1, 9, 0, 1, 3, 0, 1, 0);
      cycle(1, 0, 0, 3, 3, 10, 2, 0);
      cycle(1, 10, 0, 1, 3, 11, 1, 1);
      nop(3);
      // async reset during a load-use stall
      cycle(1, 0, 0, 3, 3, 5, TNEW_LOAD, 0);
      cycle(1, 5, 0, 0, 3, 0, 1, 0);
      cycle(1, 5, 0, 0, 3, 0, 1, 0, 1);
      cycle(1, 5, 0, 1, 3, 0, 1, 0);
      nop(2);
      // long stall on the non-forwarding instance
      cycle(1, 0, 0, 3, 3, 2, TNEW_ALU, 0);
      repeat (4) cycle(1, 2, 0, 1, 3, 0, 1, 0);
      nop(3);
      repeat (400) begin
         t0 = $urandom_range(0, 2);
         t1 = $urandom_range(0, 2);
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               (t0 == 2) ? 3 : t0, (t1 == 2) ? 3 : t1, $urandom_range(0, 7),
               $urandom_range(1, 2), $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
      end
      nop(2);
      @(negedge clk);
      #1;
      chk("queue_drained", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
